// File: rtl/ps2_key_rx_pkg.sv
// PS/2 keyboard receiver shared types and constants.
// FSM encoding, scan-code prefixes and parity helper.
package ps2_pkg;

  typedef logic [7:0] ps2_byte_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam ps2_byte_t BREAK_PREFIX = 8'hF0;
  localparam ps2_byte_t EXT_PREFIX   = 8'hE0;

  localparam int TIMEOUT_DEFAULT = 10000;

  function automatic logic odd_ok(
    input ps2_byte_t d,
    input logic      p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// Decoded key event bundle from the PS/2 receiver.
// master drives the event, slave consumes it.
interface ps2_key_rx_if;
  import ps2_pkg::*;

  ps2_byte_t scan_code;
  logic      code_valid;
  logic      is_break;
  logic      is_extended;
  logic      frame_error;
  logic      busy;

  modport master (
    output scan_code,
    output code_valid,
    output is_break,
    output is_extended,
    output frame_error,
    output busy
  );

  modport slave (
    input scan_code,
    input code_valid,
    input is_break,
    input is_extended,
    input frame_error,
    input busy
  );

endinterface

// File: rtl/ps2_key_rx_sync_edge.sv
// Two-flop synchronizers for the PS/2 lines
// plus falling-edge detection on the PS/2 clock.
module ps2_sync_edge
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic dat_s,
  output logic clk_fall
);

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_hist;

  // Clock path presets to the idle-high line level so
  // leaving reset can never look like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b00;
      clk_hist <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_hist <= clk_sync[1];
    end
  end

  assign dat_s    = dat_sync[1];
  assign clk_fall = clk_hist & ~clk_sync[1];

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard frame receiver with make/break and
// extended-prefix decoding into single key events.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  ps2_key_rx_if.master key
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  logic dat_s;
  logic clk_fall;

  ps2_sync_edge u_sync (
    .clk      (CLOCK_50),
    .rst      (reset),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .dat_s    (dat_s),
    .clk_fall (clk_fall)
  );

  ps2_state_t    state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  ps2_byte_t     sr_q, sr_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q;

  logic timeout;
  logic accept;
  logic err;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    par_d   = par_q;
    accept  = 1'b0;
    err     = 1'b0;
    timeout = (state_q != ST_IDLE) && !clk_fall
              && (tcnt_q == TLIM);
    if (timeout) begin
      err     = 1'b1;
      state_d = ST_IDLE;
    end else if (clk_fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!dat_s) begin
            state_d = ST_DATA;
            bcnt_d  = '0;
          end else begin
            err = 1'b1;
          end
        end
        ST_DATA: begin
          sr_d   = {dat_s, sr_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (dat_s && odd_ok(sr_q, par_q)) accept = 1'b1;
          else err = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
    end else if (clk_fall || state_q == ST_IDLE) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  ps2_byte_t scan_q;
  logic      valid_q, ferr_q;
  logic      brk_q, ext_q;
  logic      is_brk_q, is_ext_q;

  logic hit_brk;
  logic hit_ext;

  assign hit_brk = (sr_q == BREAK_PREFIX);
  assign hit_ext = (sr_q == EXT_PREFIX);

  // Prefixes only arm flags; the next plain byte emits the event.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      scan_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      is_brk_q <= 1'b0;
      is_ext_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= err;
      if (err) begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end else if (accept) begin
        unique case (1'b1)
          hit_brk: brk_q <= 1'b1;
          hit_ext: ext_q <= 1'b1;
          default: begin
            scan_q   <= sr_q;
            is_brk_q <= brk_q;
            is_ext_q <= ext_q;
            valid_q  <= 1'b1;
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign key.scan_code   = scan_q;
  assign key.code_valid  = valid_q;
  assign key.is_break    = is_brk_q;
  assign key.is_extended = is_ext_q;
  assign key.frame_error = ferr_q;
  assign key.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx: frames driven
// bit by bit, key events checked through a scoreboard.
module tb_ps2_key_rx;
  import ps2_pkg::*;

  localparam int H = 50;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];

  ps2_key_rx_if kif ();

  ps2_key_rx dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .key      (kif)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (kif.code_valid)
        obs_q.push_back({kif.scan_code, kif.is_break, kif.is_extended});
      if (kif.frame_error) err_cnt++;
      if (kif.code_valid && kif.frame_error) both_cnt++;
    end
  end

  task automatic send_bit(input logic b);
    ps2_dat = b;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~^b;
    if (bad_par) p = ~p;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(1'b1);
    ps2_dat = 1'b1;
  endtask

  task automatic settle();
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (kif.scan_code !== 8'h00 || kif.code_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_code got=%h/%b want=00/0",
               kif.scan_code, kif.code_valid);
    end
    checks++;
    if ({kif.is_break, kif.is_extended, kif.frame_error, kif.busy} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000",
               {kif.is_break, kif.is_extended, kif.frame_error, kif.busy});
    end
    rst = 1'b0;
    settle();
    checks++;
    if (err_cnt !== 0 || kif.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got err=%0d busy=%b want 0/0",
               err_cnt, kif.busy);
    end
  endtask

  task automatic test_make();
    int e0;
    ev_t e, o;
    e0 = err_cnt;
    exp_q.push_back('{8'h1C, 1'b0, 1'b0});
    send_frame(8'h1C, 1'b0);
    settle();
    checks++;
    if (obs_q.size() !== 1 || err_cnt !== e0) begin
      failures++;
      $display("FAIL make_count got=%0d err=%0d want=1 err=%0d",
               obs_q.size(), err_cnt, e0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL make_event got=%h want=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_break();
    ev_t e, o;
    exp_q.push_back('{8'h1C, 1'b1, 1'b0});
    send_frame(BREAK_PREFIX, 1'b0);
    settle();
    checks++;
    if (obs_q.size() !== 0) begin
      failures++;
      $display("FAIL break_prefix_silent got=%0d want=0", obs_q.size());
    end
    send_frame(8'h1C, 1'b0);
    settle();
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL break_count got=%0d want=1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL break_event got=%h want=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_ext_break();
    ev_t e, o;
    exp_q.push_back('{8'h75, 1'b1, 1'b1});
    send_frame(EXT_PREFIX, 1'b0);
    send_frame(BREAK_PREFIX, 1'b0);
    send_frame(8'h75, 1'b0);
    settle();
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL ext_break_count got=%0d want=1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL ext_break_event got=%h want=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_parity();
    int e0;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1);
    settle();
    checks++;
    if (err_cnt - e0 !== 1 || obs_q.size() !== 0) begin
      failures++;
      $display("FAIL parity_err got err=%0d valid=%0d want 1/0",
               err_cnt - e0, obs_q.size());
    end
    checks++;
    if ({kif.scan_code, kif.is_break, kif.is_extended} !== {8'h75, 2'b11}) begin
      failures++;
      $display("FAIL parity_hold got=%h/%b%b want=75/11",
               kif.scan_code, kif.is_break, kif.is_extended);
    end
    obs_q.delete();
  endtask

  task automatic test_stray_edge();
    int e0;
    e0 = err_cnt;
    send_bit(1'b1);
    settle();
    checks++;
    if (err_cnt - e0 !== 1 || kif.busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_edge got err=%0d busy=%b want 1/0",
               err_cnt - e0, kif.busy);
    end
  endtask

  task automatic test_pending_clear();
    ev_t e, o;
    exp_q.push_back('{8'h1C, 1'b0, 1'b0});
    send_frame(BREAK_PREFIX, 1'b0);
    send_frame(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b0);
    settle();
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL pend_clear_count got=%0d want=1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL pend_clear_event got=%h want=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_timeout();
    int e0;
    ev_t e, o;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    #1;
    checks++;
    if (kif.busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_busy got=%b want=1", kif.busy);
    end
    ps2_dat = 1'b1;
    repeat (10500) @(posedge clk);
    #1;
    checks++;
    if (err_cnt - e0 !== 1 || kif.busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err got err=%0d busy=%b want 1/0",
               err_cnt - e0, kif.busy);
    end
    exp_q.push_back('{8'h1C, 1'b0, 1'b0});
    send_frame(8'h1C, 1'b0);
    settle();
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL timeout_next_count got=%0d want=1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL timeout_next_event got=%h want=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    ev_t e, o;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({kif.scan_code, kif.code_valid, kif.is_break, kif.is_extended,
         kif.frame_error, kif.busy} !== 13'b0) begin
      failures++;
      $display("FAIL reset_mid_outs got=%h/%b%b%b%b%b want=00/00000",
               kif.scan_code, kif.code_valid, kif.is_break,
               kif.is_extended, kif.frame_error, kif.busy);
    end
    repeat (3) @(posedge clk);
    rst = 1'b0;
    ps2_dat = 1'b1;
    repeat (10) @(posedge clk);
    exp_q.push_back('{8'h29, 1'b0, 1'b0});
    send_frame(8'h29, 1'b0);
    settle();
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL reset_mid_count got=%0d want=1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_mid_event got=%h want=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int e0;
    ev_t e, o;
    e0 = err_cnt;
    exp_q.push_back('{8'h1C, 1'b0, 1'b0});
    exp_q.push_back('{8'h29, 1'b0, 1'b0});
    exp_q.push_back('{8'h6B, 1'b0, 1'b1});
    send_frame(8'h1C, 1'b0);
    send_frame(8'h29, 1'b0);
    send_frame(EXT_PREFIX, 1'b0);
    send_frame(8'h6B, 1'b0);
    settle();
    checks++;
    if (obs_q.size() !== 3 || err_cnt !== e0) begin
      failures++;
      $display("FAIL b2b_count got=%0d err=%0d want=3 err=%0d",
               obs_q.size(), err_cnt, e0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_event got=%h want=%h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL valid_err_overlap got=%0d want=0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext_break();
    test_parity();
    test_stray_edge();
    test_pending_clear();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
